i_cache_2way: RTL and testbench
===============================

Name: i_cache_2way

Overview:
- Parametrised two-way set-associative instruction cache; the successor to the direct-mapped 256-entry I-cache.
- Sits between CPU fetch and main memory. Serves 32-bit instruction words and refills whole lines over a req/ack handshake with variable memory latency.
- Adds over the previous generation: configurable geometry, per-set LRU replacement, explicit memory acknowledge, and a global flush (invalidate-all) input.

Parameters:
ADDR_W, 32, address width in bits
INDEX_W, 8, set-index bits; number of sets = 2**INDEX_W
WORD_SEL_W, 2, word-in-line select bits; words per line = 2**WORD_SEL_W
LINE_W, 128, line width = 32 * 2**WORD_SEL_W (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
cs  in  1  fetch request valid
addr  in  ADDR_W  fetch byte address; CPU holds it stable while cache_stall_n=0
flush  in  1  invalidate all lines (single-cycle pulse)
do  out  32  instruction word, registered
cache_stall_n  out  1  0 => CPU must stall and hold addr
mem_addr  out  ADDR_W  line-aligned refill address, registered
mem_req  out  1  refill request, held until mem_ack
mem_ack  in  1  one-cycle pulse; mem_data valid in same cycle
mem_data  in  LINE_W  refill line; word k = bits [32k+31:32k]

Behaviour:
- Address split: offset = addr[WORD_SEL_W+1:0]; word = addr[WORD_SEL_W+1:2]; index = next INDEX_W bits; tag = remaining upper bits. Tag width = ADDR_W-INDEX_W-WORD_SEL_W-2 (20 at defaults).
- Per set, per way: valid bit, tag, line data. One LRU bit per set, pointing at the way to replace.
- Valid and LRU bits are flops; data and tag arrays need no reset.
- Reset: all valid bits and LRU bits = 0, state = IDLE, do = 0, mem_req = 0, mem_addr = 0. cache_stall_n = 1 in the cycle after reset.
- States: IDLE, REFILL.
- hit = cs & (way0 hit | way1 hit), where way hit = valid & (tag match). If both ways match (illegal), way0 wins.
- IDLE, cs=0: no lookup; do holds its value; cache_stall_n=1; LRU unchanged.
- IDLE, hit:
  - do <= selected word of the hit way at the next edge (1-cycle latency).
  - LRU[index] <= ~hit_way.
  - cache_stall_n=1.
- IDLE, cs & miss:
  - cache_stall_n=0 combinationally in the same cycle.
  - Next edge: state -> REFILL, mem_addr <= {addr[ADDR_W-1:WORD_SEL_W+2], zeros}, mem_req <= 1.
  - Victim way: way0 if invalid; else way1 if invalid; else LRU[index]. Victim is latched at this edge.
- REFILL:
  - cache_stall_n=0; mem_req=1 until the ack cycle.
  - On mem_ack: write mem_data, tag and valid=1 into the victim way; LRU[index] <= ~victim; mem_req <= 0; state -> IDLE.
  - The following IDLE cycle re-looks-up the held addr, hits, and delivers do one edge later.
  - Miss penalty = memory latency + 2 cycles.
- mem_ack while in IDLE: ignored.
- flush in IDLE: all valid bits cleared at the next edge. cache_stall_n is forced to 1 that cycle; no lookup result is used and do holds.
- flush in REFILL: latched as pending. On mem_ack the line write is suppressed, all valid bits are cleared, and state -> IDLE. The following lookup misses and refills again.
- flush asserted in the same cycle as mem_ack: same as pending flush.
- rst mid-REFILL: state -> IDLE and mem_req -> 0 at that edge; any later mem_ack is ignored.
- rst has priority over flush, mem_ack and cs.
- mem_addr changes only on a miss edge; it is stable throughout REFILL.

Test Plan:
- Reset, then cs=1 addr=0x00001008 -> cache_stall_n=0 same cycle; mem_req=1 with mem_addr=0x00001000 next cycle. Ack after 3 cycles with mem_data word2=0xDEADBEEF -> do=0xDEADBEEF two edges after the ack; stall low for exactly 5 cycles.
- After the above, fetch 0x0000100C -> hit, no mem_req, do=word3 after 1 edge. Fetch 0x00002008 (same index, new tag) -> fills way1; both 0x1008 and 0x2008 then hit.
- Touch 0x1008, then fetch 0x3008 -> way1 (0x2008 line) is evicted. 0x1008 still hits; 0x2008 misses.
- Pulse flush in IDLE, then fetch 0x1008 -> miss. Pulse flush during REFILL -> ack line not retained; the same address misses again immediately.
- Assert rst during REFILL -> mem_req=0 next edge; late mem_ack ignored; next fetch misses with all valids clear.
- Run with INDEX_W=6, WORD_SEL_W=3 (256-bit lines) -> word 7 of mem_data is returned for offset 0x1C; tag compare uses bits [31:11].

Source files
------------

// File: rtl/i_cache_2way.sv
`default_nettype none
// ============================================================================
// Module   : i_cache_2way
// Purpose  : Two-way set-associative instruction cache with per-set LRU
//            replacement, whole-line refill over a req/ack handshake and a
//            global invalidate-all (flush) input.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            cs, addr          - fetch request and byte address (held while
//                                cache_stall_n = 0)
//            flush             - single-cycle invalidate-all pulse
//            do_word           - registered instruction word (the name "do"
//                                is a reserved word in SystemVerilog)
//            cache_stall_n     - 0 => CPU must stall and hold addr
//            mem_addr, mem_req - line-aligned refill address and request
//            mem_ack, mem_data - refill acknowledge pulse and line data
// Revision : 1.0 - initial release
// ============================================================================
module i_cache_2way #(
    parameter  int ADDR_W     = 32,
    parameter  int INDEX_W    = 8,
    parameter  int WORD_SEL_W = 2,
    localparam int LINE_W     = 32 << WORD_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [31:0]       do_word,
    output logic              cache_stall_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_data
);

    localparam int OFF_W = WORD_SEL_W + 2;
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Valid / LRU state lives in flops; tag and data arrays are plain storage.
    logic [SETS-1:0]   r_valid0;
    logic [SETS-1:0]   r_valid1;
    logic [SETS-1:0]   r_lru;
    logic [TAG_W-1:0]  r_tag0  [SETS];
    logic [TAG_W-1:0]  r_tag1  [SETS];
    logic [LINE_W-1:0] r_data0 [SETS];
    logic [LINE_W-1:0] r_data1 [SETS];

    logic [31:0]       r_do;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              r_victim;
    logic              r_flush_pend;

    // Lookup path on the CPU address
    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [WORD_SEL_W-1:0] w_word;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_hit_way;
    logic                  w_victim;
    logic [LINE_W-1:0]     w_hit_line;
    logic [31:0]           w_hit_word;

    // Refill target comes from the latched line address, so the write does
    // not depend on the CPU keeping addr stable.
    logic [INDEX_W-1:0] w_fill_index;
    logic [TAG_W-1:0]   w_fill_tag;

    // FSM control strobes
    logic w_do_load;
    logic w_start_miss;
    logic w_fill;
    logic w_clear_all;

    logic w_unused_bits;

    assign w_index = addr[OFF_W +: INDEX_W];
    assign w_tag   = addr[ADDR_W-1 -: TAG_W];
    assign w_word  = addr[OFF_W-1:2];

    assign w_hit0    = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
    assign w_hit1    = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
    assign w_hit     = cs && (w_hit0 || w_hit1);
    // Way0 wins if both ways match.
    assign w_hit_way = !w_hit0;

    assign w_hit_line = w_hit0 ? r_data0[w_index] : r_data1[w_index];
    assign w_hit_word = w_hit_line[32*w_word +: 32];

    // Fill empty ways first, otherwise take the way LRU points at.
    assign w_victim = !r_valid0[w_index] ? 1'b0 :
                      !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

    assign w_fill_index = r_mem_addr[OFF_W +: INDEX_W];
    assign w_fill_tag   = r_mem_addr[ADDR_W-1 -: TAG_W];

    assign w_unused_bits = ^{addr[1:0], r_mem_addr[OFF_W-1:0]};

    assign do_word  = r_do;
    assign mem_addr = r_mem_addr;
    assign mem_req  = r_mem_req;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, stall and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        cache_stall_n = 1'b1;
        w_do_load     = 1'b0;
        w_start_miss  = 1'b0;
        w_fill        = 1'b0;
        w_clear_all   = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    // Flush takes the cycle; lookup result is discarded.
                    w_clear_all = 1'b1;
                end else if (w_hit) begin
                    w_do_load = 1'b1;
                end else if (cs) begin
                    cache_stall_n = 1'b0;
                    w_start_miss  = 1'b1;
                    w_state_nxt   = REFILL;
                end
            end
            REFILL: begin
                cache_stall_n = 1'b0;
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                    // A flush seen at any point of the refill discards the line.
                    if (flush || r_flush_pend) begin
                        w_clear_all = 1'b1;
                    end else begin
                        w_fill = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control flops: valid, LRU, output word, refill interface
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid0     <= '0;
            r_valid1     <= '0;
            r_lru        <= '0;
            r_do         <= '0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_victim     <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_do_load) begin
                r_do           <= w_hit_word;
                r_lru[w_index] <= !w_hit_way;
            end
            if (w_start_miss) begin
                r_mem_addr   <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_mem_req    <= 1'b1;
                r_victim     <= w_victim;
                r_flush_pend <= 1'b0;
            end
            if (r_state == REFILL) begin
                if (mem_ack) begin
                    r_mem_req    <= 1'b0;
                    r_flush_pend <= 1'b0;
                end else if (flush) begin
                    r_flush_pend <= 1'b1;
                end
            end
            if (w_fill) begin
                if (r_victim) begin
                    r_valid1[w_fill_index] <= 1'b1;
                end else begin
                    r_valid0[w_fill_index] <= 1'b1;
                end
                r_lru[w_fill_index] <= !r_victim;
            end
            if (w_clear_all) begin
                r_valid0 <= '0;
                r_valid1 <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (no reset; qualified by the valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (r_victim) begin
                r_tag1[w_fill_index]  <= w_fill_tag;
                r_data1[w_fill_index] <= mem_data;
            end else begin
                r_tag0[w_fill_index]  <= w_fill_tag;
                r_data0[w_fill_index] <= mem_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i_cache_2way.sv
`default_nettype none
// ============================================================================
// Module   : tb_i_cache_2way
// Purpose  : Self-checking bench for i_cache_2way. Random fetch streams are
//            compared against a set/way/LRU reference model; a second
//            instance with 64 sets and 8-word lines covers the wider geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i_cache_2way;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs, flush, mem_ack;
    logic [31:0]  addr;
    logic [31:0]  do_word, mem_addr;
    logic         stall_n, mem_req;
    logic [127:0] mem_data;

    logic         cs2, mem_ack2;
    logic [31:0]  addr2;
    logic [31:0]  do2, mem_addr2;
    logic         stall2_n, mem_req2;
    logic [255:0] mem_data2;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per way/set the full line address held, valid, LRU.
    bit          m_valid [2][256];
    logic [27:0] m_line  [2][256];
    bit          m_lru   [256];

    always #5 clk = ~clk;

    i_cache_2way u_dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .flush(flush),
        .do_word(do_word), .cache_stall_n(stall_n), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    i_cache_2way #(.ADDR_W(32), .INDEX_W(6), .WORD_SEL_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .cs(cs2), .addr(addr2), .flush(1'b0),
        .do_word(do2), .cache_stall_n(stall2_n), .mem_addr(mem_addr2),
        .mem_req(mem_req2), .mem_ack(mem_ack2), .mem_data(mem_data2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
        if (la == 32'h0000_1000 && k == 2) return 32'hDEAD_BEEF;
        return (la * 32'h9E37_79B1) ^ (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word({la[31:4], 4'h0}, k);
        return l;
    endfunction

    function automatic logic [31:0] mem2_word(input logic [31:0] la, input int k);
        return la ^ {8'(k), 24'h0} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] mem2_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem2_word({la[31:5], 5'h0}, k);
        return l;
    endfunction

    function automatic bit m_lookup(input logic [31:0] a, output int way);
        int s = int'(a[11:4]);
        way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_line[w][s] == a[31:4]) begin
                way = w;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic m_clear(input bit with_lru);
        for (int s = 0; s < 256; s++) begin
            m_valid[0][s] = 1'b0;
            m_valid[1][s] = 1'b0;
            if (with_lru) m_lru[s] = 1'b0;
        end
    endtask

    task automatic m_fill(input logic [31:0] a);
        int s = int'(a[11:4]);
        int v;
        if (!m_valid[0][s])      v = 0;
        else if (!m_valid[1][s]) v = 1;
        else                     v = int'(m_lru[s]);
        m_valid[v][s] = 1'b1;
        m_line[v][s]  = a[31:4];
        m_lru[s]      = (v == 0);
    endtask

    // Fetch one word. lat = cycles from mem_req seen to mem_ack; flush_at >= 0
    // pulses flush in that cycle of the transaction (cycle 0 = first lookup).
    task automatic fetch(input logic [31:0] a, input int lat, input int flush_at);
        int way, low, age, cyc;
        bit exp_hit, done, go, ack_now, flushed;
        logic [31:0] la = {a[31:4], 4'h0};
        logic [31:0] exp_word = mem_word(la, int'(a[3:2]));
        exp_hit = m_lookup(a, way);
        flushed = !exp_hit && (flush_at > 0);
        cs = 1'b1; addr = a;
        low = 0; age = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (cyc == 0) check("stall_first", 64'(stall_n), 64'(exp_hit));
            if (cyc == 1 && !exp_hit) begin
                check("mem_req", 64'(mem_req), 64'd1);
                check("mem_addr", 64'(mem_addr), 64'(la));
            end
            if (stall_n) done = 1'b1; else low++;
            ack_now = mem_ack;
            if (ack_now) age = 0; else if (mem_req) age++;
            go = !stall_n && !ack_now && age == lat;
            @(posedge clk); #1;
            mem_ack  = go;
            mem_data = go ? mem_line(mem_addr) : '0;
            flush    = (cyc + 1 == flush_at) && !done;
            if (done) cs = 1'b0;
            cyc++;
        end
        flush = 1'b0; mem_ack = 1'b0; cs = 1'b0;
        if (!done) check("fetch_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("do", 64'(do_word), 64'(exp_word));
        check("req_idle", 64'(mem_req), 64'd0);
        check("stall_cycles", 64'(low),
              64'(exp_hit ? 0 : (flushed ? 2 * (lat + 2) : lat + 2)));
        if (exp_hit) begin
            m_lru[int'(a[11:4])] = (way == 0);
        end else begin
            if (flushed) m_clear(1'b0);
            m_fill(a);
        end
        @(posedge clk); #1;
    endtask

    // Flush while a lookup is presented: stall stays high and do holds.
    task automatic flush_idle(input logic [31:0] a);
        logic [31:0] prev = do_word;
        cs = 1'b1; addr = a; flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_n), 64'd1);
        @(posedge clk); #1;
        cs = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_do_hold", 64'(do_word), 64'(prev));
        m_clear(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic fetch2(input logic [31:0] a, input bit exp_hit);
        int low = 0, cyc = 0;
        bit done = 1'b0, go;
        cs2 = 1'b1; addr2 = a;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (cyc == 0) check("g2_stall_first", 64'(stall2_n), 64'(exp_hit));
            if (stall2_n) done = 1'b1; else low++;
            go = mem_req2 && !mem_ack2;
            @(posedge clk); #1;
            mem_ack2  = go;
            mem_data2 = go ? mem2_line(mem_addr2) : '0;
            if (done) cs2 = 1'b0;
            cyc++;
        end
        mem_ack2 = 1'b0; cs2 = 1'b0;
        if (!done) check("g2_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("g2_do", 64'(do2), 64'(mem2_word({a[31:5], 5'h0}, int'(a[4:2]))));
        check("g2_stall_cycles", 64'(low), 64'(exp_hit ? 0 : 3));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ra;
        int r, lat;
        rst = 1'b1; cs = 1'b0; addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
        cs2 = 1'b0; addr2 = '0; mem_ack2 = 1'b0; mem_data2 = '0;
        m_clear(1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_do", 64'(do_word), 64'd0);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_stall_n", 64'(stall_n), 64'd1);
        check("rst_do2", 64'(do2), 64'd0);
        @(posedge clk); #1;

        // Directed scenarios
        fetch(32'h0000_1008, 3, -1);
        fetch(32'h0000_100C, 1, -1);
        fetch(32'h0000_2008, 2, -1);
        fetch(32'h0000_1008, 1, -1);
        fetch(32'h0000_2008, 1, -1);
        fetch(32'h0000_1008, 1, -1);
        fetch(32'h0000_3008, 2, -1);
        fetch(32'h0000_1008, 1, -1);
        fetch(32'h0000_2008, 1, -1);
        flush_idle(32'h0000_1004);
        fetch(32'h0000_1008, 1, -1);
        fetch(32'h0000_5008, 3, 2);
        fetch(32'h0000_5008, 1, -1);
        fetch(32'h0000_6010, 3, 4);
        fetch(32'h0000_6014, 1, -1);

        // Reset in the middle of a refill; the late ack must be ignored.
        cs = 1'b1; addr = 32'h0000_7020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cs = 1'b0; mem_ack = 1'b1; mem_data = mem_line(32'h0000_7020);
        @(negedge clk);
        check("rst_mid_req", 64'(mem_req), 64'd0);
        check("rst_mid_stall", 64'(stall_n), 64'd1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        m_clear(1'b1);
        fetch(32'h0000_7020, 2, -1);
        fetch(32'h0000_1008, 1, -1);

        // Randomized stream over a few sets and tags to force conflicts
        for (int i = 0; i < 300; i++) begin
            ra  = {18'h0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'b00};
            r   = $urandom_range(0, 19);
            lat = $urandom_range(0, 4);
            if (r == 0)      flush_idle(ra);
            else if (r == 1) begin
                lat = $urandom_range(2, 4);
                fetch(ra, lat, $urandom_range(2, lat + 1));
            end
            else             fetch(ra, lat, -1);
        end

        // Wider geometry: 8-word lines, tag = addr[31:11], index = addr[10:5]
        fetch2(32'h0000_001C, 1'b0);
        fetch2(32'h0000_0014, 1'b1);
        fetch2(32'h0000_081C, 1'b0);
        fetch2(32'h0000_001C, 1'b1);
        fetch2(32'h0000_041C, 1'b0);
        fetch2(32'h0000_0818, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
